// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises an async reset request, merges it with a software request and
// releases NUM_CH active-low reset domains in order after a hold period, one per stagger interval.
module reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              async_rst_req,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [1:0]        rst_cause,
  output logic [1:0]        dbg_state
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0]  HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_CH-1:0]  rst_n_q;
  logic               busy_q;
  logic               done_q;
  logic [1:0]         cause_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               req_sync;
  logic               req;

  // Chain resets to "request asserted" so downstream domains stay held until it flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_rst_req};
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1];
  assign req      = req_sync | sw_rst_req;

  // Handshake-free control: req is a level; any request outside ASSERT restarts the sequence
  // and latches its cause, requests seen while already in ASSERT do not overwrite the cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_ASSERT: begin
          rst_n_q <= '0;
          if (!req) begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_LOAD;
          end
        end

        ST_HOLD: begin
          if (req) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            busy_q  <= 1'b1;
            cause_q <= {sw_rst_req, req_sync};
          end else if (cnt_q == '0) begin
            rst_n_q <= NUM_CH'(1);
            idx_q   <= IDX_W'(1);
            if (NUM_CH == 1) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RELEASE;
              cnt_q   <= STAGGER_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (req) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            busy_q  <= 1'b1;
            cause_q <= {sw_rst_req, req_sync};
          end else if (cnt_q == '0) begin
            rst_n_q <= rst_n_q | (NUM_CH'(1) << idx_q);
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              cnt_q <= STAGGER_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_DONE: begin
          if (req) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            busy_q  <= 1'b1;
            cause_q <= {sw_rst_req, req_sync};
          end
        end

        default: begin
          state_q <= ST_ASSERT;
          rst_n_q <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign rst_out_n = rst_n_q;
  assign seq_busy  = busy_q;
  assign seq_done  = done_q;
  assign rst_cause = cause_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised and directed bench for reset_sequencer; a time-since-release model predicts every
// output each cycle, plus a second small instance for the single-channel configuration.
module tb_reset_sequencer;

  localparam int NUM_CH  = 4;
  localparam int SYNC    = 2;
  localparam int HOLD    = 16;
  localparam int STAG    = 4;
  localparam int LAST_T  = HOLD + (NUM_CH - 1) * STAG;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              async_rst_req = 1'b0;
  logic              sw_rst_req = 1'b0;
  logic [NUM_CH-1:0] rst_out_n;
  logic              seq_busy, seq_done;
  logic [1:0]        rst_cause, dbg_state;

  logic [0:0]        rst1_n;
  logic              busy1, done1;
  logic [1:0]        cause1, dbg1;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  reset_sequencer #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD),
                    .STAGGER_CYCLES(STAG)) u_dut (
    .clk(clk), .reset(reset), .async_rst_req(async_rst_req), .sw_rst_req(sw_rst_req),
    .rst_out_n(rst_out_n), .seq_busy(seq_busy), .seq_done(seq_done),
    .rst_cause(rst_cause), .dbg_state(dbg_state));

  reset_sequencer #(.NUM_CH(1), .SYNC_STAGES(3), .HOLD_CYCLES(1),
                    .STAGGER_CYCLES(4)) u_dut1 (
    .clk(clk), .reset(reset), .async_rst_req(async_rst_req), .sw_rst_req(sw_rst_req),
    .rst_out_n(rst1_n), .seq_busy(busy1), .seq_done(done1),
    .rst_cause(cause1), .dbg_state(dbg1));

  // ---------------- reference model ----------------
  // Async request history delayed SYNC edges, a flag for "held in reset" and the number of
  // edges elapsed since the sequence started counting down.
  bit   sync_m[$];
  bit   m_assert;
  int   m_t;
  logic [1:0] m_cause;

  task automatic model_step();
    bit rs, rq;
    if (reset) begin
      sync_m.delete();
      for (int i = 0; i < SYNC; i++) sync_m.push_back(1'b1);
      m_assert = 1'b1;
      m_t      = 0;
      m_cause  = 2'b00;
    end else begin
      rs = sync_m.pop_front();
      sync_m.push_back(async_rst_req);
      rq = rs | sw_rst_req;
      if (m_assert) begin
        if (!rq) begin
          m_assert = 1'b0;
          m_t      = 0;
        end
      end else if (rq) begin
        m_assert = 1'b1;
        m_t      = 0;
        m_cause  = {sw_rst_req, rs};
      end else if (m_t <= LAST_T) begin
        m_t++;
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_rst();
    logic [NUM_CH-1:0] v = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (!m_assert && m_t >= HOLD + k * STAG) v[k] = 1'b1;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  int n = -1;
  int rise_n[NUM_CH];
  int done_n;
  bit chk_one = 1'b0;

  task automatic clear_rise();
    for (int k = 0; k < NUM_CH; k++) rise_n[k] = -1;
    done_n = -1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    if (reset) n = -1;
    else n++;
    check_eq("rst_out_n", 32'(rst_out_n), 32'(exp_rst()));
    check_eq("seq_busy", 32'(seq_busy), 32'(m_assert || m_t < LAST_T));
    check_eq("seq_done", 32'(seq_done), 32'(!m_assert && m_t == LAST_T));
    check_eq("rst_cause", 32'(rst_cause), 32'(m_cause));
    for (int k = 0; k < NUM_CH; k++)
      if (rst_out_n[k] && rise_n[k] < 0) rise_n[k] = n;
    if (seq_done && done_n < 0) done_n = n;
    if (chk_one) begin
      if (n == 3) begin
        check_eq("one_ch_rst_r3", 32'(rst1_n), 32'd0);
        check_eq("one_ch_done_r3", 32'(done1), 32'd0);
      end
      if (n == 4) begin
        check_eq("one_ch_rst_r4", 32'(rst1_n), 32'd1);
        check_eq("one_ch_done_r4", 32'(done1), 32'd1);
      end
      if (n == 5) check_eq("one_ch_done_r5", 32'(done1), 32'd0);
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int lim;
    int async_left;

    // Test 1: power-on release timing
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    clear_rise();
    chk_one = 1'b1;
    run(36);
    chk_one = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      check_eq("por_rise", 32'(rise_n[k]), 32'(18 + 4 * k));
    check_eq("por_done_edge", 32'(done_n), 32'd30);
    check_eq("por_cause", 32'(rst_cause), 32'd0);

    // Test 2: async request in DONE for three cycles
    async_rst_req = 1'b1;
    run(3);
    async_rst_req = 1'b0;
    check_eq("async_all_low", 32'(rst_out_n), 32'd0);
    check_eq("async_cause", 32'(rst_cause), 32'd1);
    run(40);

    // Test 3: software pulse after channel 1 released
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    lim = 0;
    while (!(rst_out_n[1] && !rst_out_n[2]) && lim < 60) begin
      step();
      lim++;
    end
    check_eq("wait_ch1_released", 32'(lim < 60), 32'd1);
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    s = n;
    clear_rise();
    check_eq("sw_all_low", 32'(rst_out_n), 32'd0);
    check_eq("sw_cause", 32'(rst_cause), 32'd2);
    run(35);
    check_eq("sw_ch0_rise", 32'(rise_n[0] - s), 32'd17);
    check_eq("sw_ch3_rise", 32'(rise_n[3] - s), 32'd29);

    // Test 4: both sources reach the FSM together, then a second request during ASSERT
    async_rst_req = 1'b1; run(2);
    sw_rst_req = 1'b1;    step();
    async_rst_req = 1'b0; sw_rst_req = 1'b0; step();
    sw_rst_req = 1'b1;    step();
    sw_rst_req = 1'b0;
    check_eq("both_cause", 32'(rst_cause), 32'd3);
    run(40);

    // Test 5: reset mid-RELEASE while the async request is held
    async_rst_req = 1'b1;
    step();
    async_rst_req = 1'b0;
    run(24);
    async_rst_req = 1'b1;
    step();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(6);
    check_eq("rst_held_low", 32'(rst_out_n), 32'd0);
    async_rst_req = 1'b0;
    clear_rise();
    s = n;
    run(40);
    check_eq("rst_hold_ch0", 32'(rise_n[0] - s), 32'd19);

    // Randomised traffic
    async_left = 0;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 249) == 0);
      if (async_left > 0) begin
        async_rst_req = 1'b1;
        async_left--;
      end else begin
        async_rst_req = 1'b0;
        if ($urandom_range(0, 39) == 0) async_left = $urandom_range(1, 4);
      end
      sw_rst_req = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b0; async_rst_req = 1'b0; sw_rst_req = 1'b0;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
